mac_array_writeback: RTL and testbench

- Write-back end of the MAC adder-tree array interface.
- Takes the N_adder_tree x 16-bit result word that the adder-tree array presents for the next layer's BRAM. Aligns it to the array's pipeline latency, then writes one word per output pixel into the destination BRAM at sequential addresses from a programmed base.
- Reports busy, done and overrun to the layer controller.

---
 rtl/mac_array_writeback.sv | 144 ++++++++++++++
 tb/tb_mac_array_writeback.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_writeback.sv
// Write-back stage of the MAC adder-tree array: aligns tree results to the
// array pipeline latency and streams one word per pixel into the next-layer BRAM.
module mac_array_writeback #(
  parameter int N_adder_tree = 16,
  parameter int DW           = 16,
  parameter int AW           = 12,
  parameter int PIPE_LAT     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AW-1:0]              base_addr,
  input  logic [AW-1:0]              num_pix,
  input  logic                       res_valid,
  input  logic [N_adder_tree*DW-1:0] res_data,
  output logic                       bram2_we,
  output logic [AW-1:0]              bram2_addr,
  output logic [N_adder_tree*DW-1:0] bram2_din,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam int BW = N_adder_tree * DW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] num_q;
  logic [AW-1:0] issued_q;
  logic [AW-1:0] written_q;
  logic [AW-1:0] addr_q;
  logic [BW-1:0] din_q;
  logic          we_q;
  logic          busy_q;
  logic          done_q;
  logic          ovr_q;

  logic [PIPE_LAT-1:0] dly_q;
  logic [PIPE_LAT-1:0] dly_d;

  logic acc_vld;
  logic last_iss;
  logic aligned;

  assign acc_vld  = (state_q == S_RUN) && res_valid;
  assign last_iss = (issued_q + AW'(1)) == num_q;
  assign aligned  = dly_q[PIPE_LAT-1];

  // Only pulses accepted in RUN enter the delay line.
  always_comb begin
    dly_d    = '0;
    dly_d[0] = acc_vld;
    for (int i = 1; i < PIPE_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      issued_q  <= '0;
      written_q <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      dly_q     <= '0;
    end else begin
      dly_q  <= dly_d;
      we_q   <= 1'b0;
      done_q <= 1'b0;

      // The output register doubles as the capture register.
      if (aligned) begin
        we_q      <= 1'b1;
        din_q     <= res_data;
        addr_q    <= base_q + written_q;
        written_q <= written_q + AW'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            num_q     <= num_pix;
            issued_q  <= '0;
            written_q <= '0;
            ovr_q     <= 1'b0;
            if (num_pix == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (res_valid) begin
            issued_q <= issued_q + AW'(1);
            if (last_iss) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (res_valid) begin
            ovr_q <= 1'b1;
          end
          if (written_q == num_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bram2_we   = we_q;
  assign bram2_addr = addr_q;
  assign bram2_din  = din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_mac_array_writeback.sv
// Directed bench for mac_array_writeback: a scoreboard queue holds the
// address, data and cycle each accepted pulse should write.
module tb_mac_array_writeback;

  localparam int NT = 16;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int PL = 3;
  localparam int BW = NT * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          res_valid = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_pix = '0;
  logic [BW-1:0] res_data = '0;
  logic          bram2_we;
  logic [AW-1:0] bram2_addr;
  logic [BW-1:0] bram2_din;
  logic          busy;
  logic          done;
  logic          overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cyc = -1;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    int            c;
  } exp_t;

  exp_t sb[$];

  logic          m_run = 1'b0;
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] m_num = '0;
  logic [AW-1:0] m_k = '0;

  always #5 clk = ~clk;

  mac_array_writeback #(
    .N_adder_tree(NT),
    .DW(DW),
    .AW(AW),
    .PIPE_LAT(PL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .num_pix(num_pix),
    .res_valid(res_valid),
    .res_data(res_data),
    .bram2_we(bram2_we),
    .bram2_addr(bram2_addr),
    .bram2_din(bram2_din),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  function automatic logic [BW-1:0] mk(input int c);
    logic [BW-1:0] r;
    for (int i = 0; i < NT; i++) begin
      r[i*DW +: DW] = 16'(c * 37 + i * 4099) ^ 16'hA5C3;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    res_data = mk(cyc);
    if (done) done_cyc = cyc;
    if (bram2_we) begin
      if (sb.size() == 0) begin
        chk("unexp_we", BW'(bram2_we), '0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", BW'(bram2_addr), BW'(e.a));
        chk("wr_din", bram2_din, e.d);
        chk("wr_cyc", BW'(cyc), BW'(e.c));
      end
    end
  endtask

  task automatic step(input logic s, input logic v);
    start = s;
    res_valid = v;
    if (v && m_run) begin
      sb.push_back('{a: m_base + m_k, d: mk(cyc + PL), c: cyc + PL + 1});
      m_k = m_k + 1'b1;
      if (m_k == m_num) m_run = 1'b0;
    end
    tick();
    start = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [AW-1:0] n,
                    input logic v);
    base_addr = b;
    num_pix = n;
    t0 = cyc;
    done_cyc = -1;
    m_base = b;
    m_num = n;
    m_k = '0;
    m_run = 1'b0;
    step(1'b1, v);
    m_run = (n != '0);
  endtask

  task automatic wait_done(input string tag, input int exp_rel);
    int n = 0;
    while (done_cyc < 0 && n < 200) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk({tag, "_done_cyc"}, BW'(done_cyc - t0), BW'(exp_rel));
    chk({tag, "_busy_at_done"}, BW'(busy), '0);
    chk({tag, "_sb_empty"}, BW'(sb.size()), '0);
    step(1'b0, 1'b0);
    chk({tag, "_done_1cyc"}, BW'(done), '0);
  endtask

  initial begin
    res_data = mk(0);
    tick();
    tick();
    chk("rst_we", BW'(bram2_we), '0);
    chk("rst_addr", BW'(bram2_addr), '0);
    chk("rst_din", bram2_din, '0);
    chk("rst_busy", BW'(busy), '0);
    chk("rst_done", BW'(done), '0);
    chk("rst_ovr", BW'(overrun), '0);
    rst = 1'b1;
    step(1'b0, 1'b0);

    // basic run with a start ignored mid-run
    go(12'h010, 12'd4, 1'b0);
    chk("t1_busy_r1", BW'(busy), BW'(1));
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    base_addr = 12'h7AA;
    num_pix = 12'd9;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("t1_busy_r12", BW'(busy), BW'(1));
    wait_done("t1", 16);
    chk("t1_hold_addr", BW'(bram2_addr), BW'(12'h013));
    chk("t1_hold_din", bram2_din, mk(t0 + 14));
    chk("t1_ovr", BW'(overrun), '0);

    // res_valid in IDLE
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("idle_busy", BW'(busy), '0);

    // back-to-back, start together with an uncounted res_valid
    go(12'h200, 12'd3, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    wait_done("b2b", 8);

    // address wrap
    go(12'hFFE, 12'd4, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    wait_done("wrap", 9);

    // zero length
    go(12'h123, 12'd0, 1'b0);
    chk("zero_done", BW'(done), BW'(1));
    chk("zero_busy", BW'(busy), '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("zero_done_cyc", BW'(done_cyc - t0), BW'(1));
    chk("zero_busy_after", BW'(busy), '0);

    // overrun
    go(12'h300, 12'd2, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("ovr_set", BW'(overrun), BW'(1));
    wait_done("ovr", 7);
    chk("ovr_held", BW'(overrun), BW'(1));
    go(12'h310, 12'd1, 1'b0);
    chk("ovr_clr", BW'(overrun), '0);
    step(1'b0, 1'b1);
    wait_done("ovr_next", 6);

    // reset mid-run
    go(12'h040, 12'd4, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rst = 1'b0;
    step(1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    m_run = 1'b0;
    chk("mrst_we", BW'(bram2_we), '0);
    chk("mrst_addr", BW'(bram2_addr), '0);
    chk("mrst_din", bram2_din, '0);
    chk("mrst_busy", BW'(busy), '0);
    chk("mrst_done", BW'(done), '0);
    chk("mrst_ovr", BW'(overrun), '0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    go(12'h050, 12'd2, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    wait_done("mrst_fresh", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
